mc_ctrl_unit: RTL
=================

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clock CLK, reset Reset.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction opcode from instruction register; valid in ID.
REQ-005 zero  input  1  ALU zero flag; valid in EXE.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 PCWE  output  1  PC write enable, pulse.
REQ-008 PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-009 IRWE, RegWE, MemRd, MemWr  output  1 each  IR load, register-file write, memory read, memory write.
REQ-010 ALUSrcB  output  1  0 register, 1 immediate.
REQ-011 ALUOp  output  3  000 add, 001 sub, 010 R-funct.
REQ-012 state  output  3  current state code, debug.
REQ-013 halted  output  1  1 while in HALT.

Function
REQ-014 States SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
REQ-015 Opcodes SHALL be R=000000, ADDI=000001, LW=110000, SW=110001, BEQ=110100, J=111000, HALT=111111; any other opcode is illegal.
REQ-016 IF: MemRd=1; stay while mem_ready=0; when mem_ready=1, IRWE=1 that cycle, next ID.
REQ-017 ID: latch opcode into op_q; HALT opcode -> HALT; J -> PCWE=1, PCSrc=10, next IF; else next EXE.
REQ-018 EXE: R -> ALUOp=010, ALUSrcB=0, next WB; ADDI/LW/SW -> ALUOp=000, ALUSrcB=1; ADDI -> WB; LW/SW -> MEM.
REQ-019 EXE BEQ: ALUOp=001, ALUSrcB=0, PCWE=1, PCSrc=01 if zero=1 else 00, next IF.
REQ-020 EXE illegal opcode: PCWE=1, PCSrc=00, next IF (treated as NOP).
REQ-021 MEM LW: MemRd=1; wait for mem_ready=1, then next WB.
REQ-022 MEM SW: MemWr=1; wait for mem_ready=1; in that cycle PCWE=1, PCSrc=00; next IF.
REQ-023 WB: RegWE=1, PCWE=1, PCSrc=00, next IF.
REQ-024 HALT: all enables 0, halted=1, remains until Reset asserted.
REQ-025 PCWE SHALL pulse exactly one cycle per retired instruction; never in IF or HALT.
REQ-026 Outputs SHALL be combinational from state, op_q, zero, mem_ready; enables not listed for a state are 0; PCSrc=00, ALUOp=000, ALUSrcB=0 by default.
REQ-027 Latency with mem_ready held 1: J 2, BEQ 3, SW 4, R/ADDI 4, LW 5 cycles.
REQ-028 MemRd and MemWr SHALL never both be 1.

Reset
REQ-029 Reset=0 SHALL immediately force state=IF, op_q=000000, and all enables (PCWE, IRWE, RegWE, MemRd, MemWr) and halted to 0, regardless of CLK.
REQ-030 Reset asserted mid-instruction, including mid memory wait, SHALL abandon it with no PCWE/RegWE pulse; fetch restarts in IF on the first rising edge after release.

Structure
REQ-031 State encodings, opcode constants and PCSrc/ALUOp codes SHALL reside in shared package mc_pkg.
REQ-032 Sub-module mc_decode SHALL map op_q to instruction class; FSM stays in mc_ctrl_unit.

Verification
REQ-033 ADDI, mem_ready=1 -> IF,ID,EXE,WB; IRWE cycle 1, RegWE+PCWE cycle 4, PCSrc=00.
REQ-034 BEQ with zero=1 -> PCWE cycle 3, PCSrc=01; zero=0 -> PCSrc=00.
REQ-035 LW with mem_ready low 3 cycles in MEM -> MemRd held 4 cycles, WB on cycle 8, one PCWE.
REQ-036 J -> PCWE, PCSrc=10 in ID (cycle 2); next cycle state=000.
REQ-037 HALT opcode -> state=111, halted=1 for 20 cycles, no enables; Reset=0 -> state=000 asynchronously.
REQ-038 Reset pulse during SW mem wait -> MemWr drops immediately, no PCWE; opcode 101010 -> NOP, PCWE in EXE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, instruction
// classes and the PCSrc / ALUOp codes driven onto the datapath.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_HALT,
        CLS_ILL
    } instr_cls_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

endpackage

// File: rtl/mc_decode.sv
// Opcode to instruction-class decoder; anything unrecognised is CLS_ILL.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  op,
    output instr_cls_e  cls
);

    always_comb begin
        cls = CLS_ILL;
        case (op)
            OP_R:    cls = CLS_R;
            OP_ADDI: cls = CLS_ADDI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back, driving datapath enables combinationally from the current state.
//
//   state | meaning
//   IF    | fetch, MemRd until mem_ready, then load IR
//   ID    | latch opcode; J retires here, HALT parks
//   EXE   | ALU op; BEQ and illegal opcodes retire here
//   MEM   | LW read / SW write, wait on mem_ready
//   WB    | register write, retire
//   HALT  | idle until reset
module mc_ctrl_unit
    import mc_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWE,
    output logic [1:0] PCSrc,
    output logic       IRWE,
    output logic       RegWE,
    output logic       MemRd,
    output logic       MemWr,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [2:0] state,
    output logic       halted
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    instr_cls_e id_cls, ex_cls;

    logic pcwe_c, irwe_c, regwe_c, memrd_c, memwr_c, halted_c;

    // ID must act on the live opcode; later states use the latched copy.
    mc_decode u_dec_id (.op(opcode), .cls(id_cls));
    mc_decode u_dec_ex (.op(op_q),   .cls(ex_cls));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IF;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pcwe_c   = 1'b0;
        irwe_c   = 1'b0;
        regwe_c  = 1'b0;
        memrd_c  = 1'b0;
        memwr_c  = 1'b0;
        halted_c = 1'b0;
        PCSrc    = PCSRC_SEQ;
        ALUOp    = ALUOP_ADD;
        ALUSrcB  = 1'b0;

        case (state_q)
            ST_IF: begin
                memrd_c = 1'b1;
                if (mem_ready) begin
                    irwe_c  = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                op_d = opcode;
                case (id_cls)
                    CLS_HALT: state_d = ST_HALT;
                    CLS_J: begin
                        pcwe_c  = 1'b1;
                        PCSrc   = PCSRC_JMP;
                        state_d = ST_IF;
                    end
                    default:  state_d = ST_EXE;
                endcase
            end
            ST_EXE: begin
                case (ex_cls)
                    CLS_R: begin
                        ALUOp   = ALUOP_FUNCT;
                        state_d = ST_WB;
                    end
                    CLS_ADDI: begin
                        ALUSrcB = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ALUSrcB = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BEQ: begin
                        ALUOp   = ALUOP_SUB;
                        pcwe_c  = 1'b1;
                        PCSrc   = zero ? PCSRC_BR : PCSRC_SEQ;
                        state_d = ST_IF;
                    end
                    default: begin
                        // illegal opcode retires as a NOP
                        pcwe_c  = 1'b1;
                        state_d = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                if (ex_cls == CLS_LW) begin
                    memrd_c = 1'b1;
                    if (mem_ready) state_d = ST_WB;
                end else if (ex_cls == CLS_SW) begin
                    memwr_c = 1'b1;
                    if (mem_ready) begin
                        pcwe_c  = 1'b1;
                        state_d = ST_IF;
                    end
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_WB: begin
                regwe_c = 1'b1;
                pcwe_c  = 1'b1;
                state_d = ST_IF;
            end
            ST_HALT: halted_c = 1'b1;
            default: state_d = ST_IF;
        endcase
    end

    // Enables are gated by Reset so they drop the instant reset asserts,
    // even though IF would otherwise drive MemRd.
    assign PCWE   = pcwe_c   & Reset;
    assign IRWE   = irwe_c   & Reset;
    assign RegWE  = regwe_c  & Reset;
    assign MemRd  = memrd_c  & Reset;
    assign MemWr  = memwr_c  & Reset;
    assign halted = halted_c & Reset;
    assign state  = state_q;

endmodule
